// File: rtl/xprop_result_checker.sv
// xprop_result_checker
//   Consumes a stream of 1-bit comparison results, each carried as a
//   dual-rail pair (value + is-X). Every result is checked against an
//   expected 4-state value, also dual-rail. The block counts matches,
//   mismatches and X results. It stops after a programmed number of results.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, cycle_max      arm a run of cycle_max results (IDLE/DONE only)
//   clear                 return to IDLE, zero counters (beats start/accept)
//   in_valid / in_ready   handshake for one result/expected pair
//   in_data, in_is_x      observed result (value ignored when is_x)
//   exp_data, exp_is_x    expected result (value ignored when is_x)
//   match_count, mismatch_count, x_count   run statistics
//   first_mm_idx, first_mm_valid           index of first mismatch in run
//   busy, done, pass      run status; pass = done with no mismatches
module xprop_result_checker #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] cycle_max,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic             in_is_x,
    input  logic             exp_data,
    input  logic             exp_is_x,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] first_mm_idx,
    output logic             first_mm_valid,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Dual-rail encoded bit: is_x set means the value rail carries no meaning.
    typedef struct packed {
        logic data;
        logic is_x;
    } dr_bit_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] mm_q, mm_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] fmi_q, fmi_d;
    logic             fmv_q, fmv_d;

    dr_bit_t res, expd;
    logic    accept;
    logic    pair_match;

    assign res      = '{data: in_data,  is_x: in_is_x};
    assign expd     = '{data: exp_data, is_x: exp_is_x};
    assign in_ready = (state_q == S_RUN);
    assign accept   = in_valid && in_ready;

    // An expected X only matches an X result; a known expected value needs a
    // known result with the same value.
    assign pair_match = expd.is_x ? res.is_x
                                  : (!res.is_x && (res.data == expd.data));

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        idx_d    = idx_q;
        match_d  = match_q;
        mm_d     = mm_q;
        x_d      = x_q;
        fmi_d    = fmi_q;
        fmv_d    = fmv_q;

        if (clear) begin
            state_d = S_IDLE;
            idx_d   = '0;
            match_d = '0;
            mm_d    = '0;
            x_d     = '0;
            fmi_d   = '0;
            fmv_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target_d = cycle_max;
                        idx_d    = '0;
                        match_d  = '0;
                        mm_d     = '0;
                        x_d      = '0;
                        fmv_d    = 1'b0;
                        // An empty run completes immediately.
                        state_d  = (cycle_max != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        idx_d = idx_q + ONE;
                        if (pair_match) begin
                            match_d = match_q + ONE;
                        end else begin
                            mm_d = mm_q + ONE;
                            if (!fmv_q) begin
                                fmi_d = idx_q;
                                fmv_d = 1'b1;
                            end
                        end
                        if (res.is_x) begin
                            x_d = x_q + ONE;
                        end
                        if (idx_q == target_q - ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            idx_q    <= '0;
            match_q  <= '0;
            mm_q     <= '0;
            x_q      <= '0;
            fmi_q    <= '0;
            fmv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            idx_q    <= idx_d;
            match_q  <= match_d;
            mm_q     <= mm_d;
            x_q      <= x_d;
            fmi_q    <= fmi_d;
            fmv_q    <= fmv_d;
        end
    end

    assign match_count    = match_q;
    assign mismatch_count = mm_q;
    assign x_count        = x_q;
    assign first_mm_idx   = fmi_q;
    assign first_mm_valid = fmv_q;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (mm_q == '0);

endmodule

// File: tb/tb_xprop_result_checker.sv
module tb_xprop_result_checker;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] cycle_max = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_data = 1'b0;
    logic             in_is_x = 1'b0;
    logic             exp_data = 1'b0;
    logic             exp_is_x = 1'b0;
    logic [CNT_W-1:0] match_count, mismatch_count, x_count, first_mm_idx;
    logic             first_mm_valid, busy, done, pass;

    xprop_result_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .cycle_max(cycle_max),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_is_x(in_is_x),
        .exp_data(exp_data), .exp_is_x(exp_is_x),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .x_count(x_count), .first_mm_idx(first_mm_idx),
        .first_mm_valid(first_mm_valid),
        .busy(busy), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned m;
        int unsigned mm;
        int unsigned x;
        bit          fmv;
        int unsigned fmi;
        bit          pass;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Stimulus runs one time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input bit v, input bit d, input bit dx, input bit e, input bit ex);
        in_valid = v; in_data = d; in_is_x = dx; exp_data = e; exp_is_x = ex;
    endtask

    task automatic send(input bit v, input bit d, input bit dx, input bit e, input bit ex);
        set_pair(v, d, dx, e, ex);
        tick();
    endtask

    task automatic pulse_start(input int unsigned cm);
        cycle_max = cm;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input int unsigned m, input int unsigned mm, input int unsigned x,
                            input bit fmv, input int unsigned fmi, input bit ps);
        exp_t e;
        e.m = m; e.mm = mm; e.x = x; e.fmv = fmv; e.fmi = fmi; e.pass = ps;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " pass"}, 32'(pass), 0);
        chk({tag, " in_ready"}, 32'(in_ready), 0);
        chk({tag, " match"}, match_count, 0);
        chk({tag, " mismatch"}, mismatch_count, 0);
        chk({tag, " x"}, x_count, 0);
        chk({tag, " fmi"}, first_mm_idx, 0);
        chk({tag, " fmv"}, 32'(first_mm_valid), 0);
    endtask

    // Monitor: each completed run (done rising) is one DUT result; compare
    // it against the next expected record in the scoreboard.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected run completion", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("run match_count", match_count, e.m);
                chk("run mismatch_count", mismatch_count, e.mm);
                chk("run x_count", x_count, e.x);
                chk("run first_mm_valid", 32'(first_mm_valid), 32'(e.fmv));
                if (e.fmv) chk("run first_mm_idx", first_mm_idx, e.fmi);
                chk("run pass", 32'(pass), 32'(e.pass));
            end
        end
        done_prev <= done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // 10 matching 0-vs-0 pairs, valid held high.
        push_exp(10, 0, 0, 0, 0, 1);
        pulse_start(10);
        chk("t1 busy after start", 32'(busy), 1);
        chk("t1 in_ready after start", 32'(in_ready), 1);
        set_pair(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 8) chk("t1 done before last accept", 32'(done), 0);
        end
        chk("t1 done after last accept", 32'(done), 1);
        chk("t1 in_ready after last accept", 32'(in_ready), 0);
        set_pair(0, 0, 0, 0, 0);

        // Dual-rail match rule and first-mismatch capture.
        push_exp(2, 2, 2, 1, 1, 0);
        pulse_start(4);
        send(1, 0, 1, 0, 1);   // X vs X: match
        send(1, 0, 1, 1, 0);   // X vs 1: mismatch at idx 1
        chk("t2 fmv one cycle after mismatch", 32'(first_mm_valid), 1);
        chk("t2 fmi one cycle after mismatch", first_mm_idx, 1);
        send(1, 1, 0, 1, 0);   // 1 vs 1: match
        send(1, 0, 0, 1, 0);   // 0 vs 1: mismatch, must not move fmi
        chk("t2 fmi held", first_mm_idx, 1);
        set_pair(0, 0, 0, 0, 0);

        // Gapped valid; a start pulse in RUN must be ignored.
        push_exp(3, 0, 0, 0, 0, 1);
        pulse_start(3);
        send(1, 1, 0, 1, 0);
        start = 1'b1; cycle_max = 5;
        send(0, 1, 0, 1, 0);
        start = 1'b0;
        send(0, 1, 0, 1, 0);
        send(1, 1, 0, 1, 0);
        chk("t3 done after 4th cycle", 32'(done), 0);
        chk("t3 match after 2 accepts", match_count, 2);
        send(1, 1, 0, 1, 0);
        chk("t3 done after 5th cycle", 32'(done), 1);
        set_pair(0, 0, 0, 0, 0);

        // cycle_max == 0 completes immediately.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4 done after clear", 32'(done), 0);
        push_exp(0, 0, 0, 0, 0, 1);
        pulse_start(0);
        chk("t4 done", 32'(done), 1);
        chk("t4 in_ready", 32'(in_ready), 0);
        set_pair(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4 in_ready stays low", 32'(in_ready), 0);
        end
        chk("t4 match unchanged", match_count, 0);
        set_pair(0, 0, 0, 0, 0);

        // Re-arm from DONE after a failing run.
        push_exp(1, 1, 0, 1, 0, 0);
        pulse_start(2);
        send(1, 0, 0, 1, 0);
        send(1, 1, 0, 1, 0);
        set_pair(0, 0, 0, 0, 0);
        chk("t5 pass low", 32'(pass), 0);
        push_exp(1, 0, 0, 0, 0, 1);
        pulse_start(1);
        chk("t5 busy after rearm", 32'(busy), 1);
        chk("t5 mismatch cleared", mismatch_count, 0);
        chk("t5 fmv cleared", 32'(first_mm_valid), 0);
        send(1, 0, 0, 0, 0);
        set_pair(0, 0, 0, 0, 0);
        chk("t5 pass", 32'(pass), 1);

        // rst in the middle of a run; the pair in the reset cycle is dropped.
        pulse_start(8);
        send(1, 1, 0, 1, 0);
        send(1, 1, 0, 0, 0);
        send(1, 0, 1, 0, 1);
        chk("t6 x before rst", x_count, 1);
        chk("t6 fmv before rst", 32'(first_mm_valid), 1);
        rst = 1'b1;
        send(1, 1, 0, 1, 0);
        rst = 1'b0;
        set_pair(0, 0, 0, 0, 0);
        chk_reset_vals("t6 after rst");
        push_exp(2, 0, 0, 0, 0, 1);
        pulse_start(2);
        send(1, 1, 0, 1, 0);
        send(1, 0, 0, 0, 0);
        set_pair(0, 0, 0, 0, 0);

        // clear beats start in DONE, and beats an accept in RUN.
        clear = 1'b1; start = 1'b1; cycle_max = 3;
        tick();
        clear = 1'b0; start = 1'b0;
        chk("t7 busy after clear+start", 32'(busy), 0);
        chk("t7 done after clear+start", 32'(done), 0);
        chk("t7 match after clear+start", match_count, 0);
        pulse_start(3);
        send(1, 1, 0, 1, 0);
        chk("t7 match mid-run", match_count, 1);
        clear = 1'b1;
        send(1, 1, 0, 1, 0);
        clear = 1'b0;
        set_pair(0, 0, 0, 0, 0);
        chk("t7 match after clear", match_count, 0);
        chk("t7 busy after clear", 32'(busy), 0);
        chk("t7 in_ready after clear", 32'(in_ready), 0);

        repeat (3) tick();
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xprop_result_checker.md
# xprop_result_checker

Downstream consumer for the X-propagation comparator benches. Accepts a stream of 1-bit comparison results that have been dual-rail encoded as value plus is-X. Checks each result against an expected 4-state value and counts matches, mismatches and X results. Finishes after a programmed number of results, replacing the ad-hoc cycle_count/cycle_max loop with a synthesizable, self-checking stage.

## Interface
- CNT_W, 32, width of all counters, cycle_max and index outputs
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a check run (honoured in IDLE and DONE only)
- clear  in  1  returns to IDLE from any state; counters zeroed
- cycle_max  in  CNT_W  number of results to check; sampled on accepted start
- in_valid  in  1  result/expected pair valid
- in_ready  out  1  checker accepts pair this cycle
- in_data  in  1  result value bit (ignored when in_is_x=1)
- in_is_x  in  1  result is X
- exp_data  in  1  expected value bit (ignored when exp_is_x=1)
- exp_is_x  in  1  X is the expected result
- match_count  out  CNT_W  results that matched
- mismatch_count  out  CNT_W  results that mismatched
- x_count  out  CNT_W  results with in_is_x=1, regardless of expectation
- first_mm_idx  out  CNT_W  0-based index of first mismatch in the run
- first_mm_valid  out  1  first_mm_idx holds a captured index
- busy  out  1  state==RUN
- done  out  1  state==DONE
- pass  out  1  done && mismatch_count==0

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start with cycle_max!=0: latch target=cycle_max, zero all counters, idx and first_mm_valid; go to RUN.
  - start with cycle_max==0: same clears; go directly to DONE.
- RUN:
  - in_ready=1 (combinational from state).
  - Accept when in_valid && in_ready.
  - On accept, idx increments.
  - When the accept has idx==target-1, go to DONE.
- DONE: holds all outputs. start behaves as in IDLE (re-arm). Otherwise stays.
- clear (any state): go to IDLE, zero counters, idx, first_mm_idx and first_mm_valid. clear has priority over start and over an accept in the same cycle.
- in_ready=0 in IDLE and DONE; in_valid is ignored there.
- Match rule per accepted pair:
  - exp_is_x=1: match iff in_is_x=1.
  - exp_is_x=0: match iff in_is_x=0 && in_data==exp_data.
  - Exactly one of match_count/mismatch_count increments per accept.
  - x_count increments iff in_is_x=1, independent of the match rule.
- First mismatch: on the first mismatching accept of a run, first_mm_idx=idx of that accept and first_mm_valid=1. Later mismatches do not update it.
- Width rules:
  - idx and all counters are CNT_W bits.
  - Counts never exceed target ≤ 2^CNT_W−1, so no wrap occurs and no saturation logic is needed.
- A start pulse in RUN is ignored; the run continues.

## Timing
- Reset values: state=IDLE, in_ready=0, all counters=0, first_mm_idx=0, first_mm_valid=0, busy=0, done=0, pass=0.
- start in cycle N → busy=1 and in_ready=1 in N+1.
- Accept in cycle N → counters and first_mm_* reflect that pair in N+1. Latency is 1 cycle.
- Final accept in cycle N → done=1, in_ready=0 and final counts all visible in N+1.
- Back-to-back accepts every cycle are supported, so throughput is 1 pair/cycle.
- rst mid-RUN → next cycle matches the reset values. The pair presented in the reset cycle is not counted.
- clear behaves identically to rst except for its state-priority ordering with start (see Operation).
- pass is combinational from done and mismatch_count.

## Test plan
- Reset then start, cycle_max=10, 10 pairs of in=0 vs exp=0, in_valid held high → done in the cycle after the 10th accept; match=10, mismatch=0, x=0, pass=1.
- cycle_max=4; pairs (in X, exp X), (in X, exp 1), (in 1, exp 1), (in 0, exp 1) → match=2, mismatch=2, x=2, first_mm_idx=1, first_mm_valid=1, pass=0.
- cycle_max=3 with in_valid toggling 1,0,0,1,1 → exactly 3 accepts counted, done after the 5th cycle; idle cycles add nothing.
- start with cycle_max=0 → done=1 next cycle, all counts 0, pass=1, in_ready never asserts.
- cycle_max=8; assert rst after 3 accepts → all outputs at reset values next cycle. New start with cycle_max=2 completes with counts 2 total.
- Completed run (done=1, mismatch=1); pulse start with cycle_max=1 → counters cleared, RUN; one matching pair → done with match=1, mismatch=0, pass=1.
